udp_stream_arbiter: RTL and testbench
=====================================

# udp_stream_arbiter

Packet-level round-robin arbiter that shares the single 64-bit AXI4-Stream egress toward the 10G QSFP MAC among `NUM_SRC` UDP stream generators.
- Sits between the `udp_stream` packet sources and the MAC TX port.
- Grants one source at a time and holds the grant for a whole packet (until `tlast`), so packets are never interleaved.
- Optionally enforces a maximum packet length.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `C_AXIS_TDATA_WIDTH`, 64: stream data width.
- `C_AXIS_TKEEP_WIDTH`, 8: `C_AXIS_TDATA_WIDTH/8`.
- `MAX_BEATS`, 256: watchdog packet-length limit in beats. Used only with `UDP_ARB_WATCHDOG_EN`.

Ports:
- `m00_axis_aclk`  in  1  single clock for all logic.
- `m00_axis_aresetn`  in  1  synchronous, active-low reset.
- `s_axis_tdata`  in  NUM_SRC*64  source data, source k at bits [64k+63:64k].
- `s_axis_tkeep`  in  NUM_SRC*8  source byte enables.
- `s_axis_tvalid`  in  NUM_SRC  per-source valid.
- `s_axis_tlast`  in  NUM_SRC  per-source end of packet.
- `s_axis_tuser`  in  NUM_SRC  per-source error/user bit.
- `s_axis_tready`  out  NUM_SRC  per-source ready.
- `m00_axis_tdata`  out  64  egress data.
- `m00_axis_tkeep`  out  8  egress byte enables.
- `m00_axis_tvalid`  out  1  egress valid.
- `m00_axis_tlast`  out  1  egress end of packet.
- `m00_axis_tuser`  out  1  egress user bit; 1 marks a bad frame to the MAC.
- `m00_axis_tready`  in  1  egress ready.
- `grant_id`  out  $clog2(NUM_SRC)  index of the currently or last granted source.
- `busy`  out  1  high while a packet is in flight (state not IDLE).

## Operation
State machine states: IDLE, XFER, DRAIN. DRAIN exists only with the watchdog.

IDLE:
- All `s_axis_tready` are 0; `m00_axis_tvalid` is 0.
- If any `s_axis_tvalid` is set, select a winner by round-robin starting at `(last_grant+1) mod NUM_SRC`. Register `grant_id`, update `last_grant`, go to XFER.

XFER:
- Outputs are driven by a combinational mux from the granted source: `m00_axis_{tdata,tkeep,tvalid,tlast,tuser}` = source[`grant_id`].
- `s_axis_tready[grant_id]` = `m00_axis_tready`; all other readies are 0.
- On a handshake with `tlast`=1, go to IDLE.

Other rules:
- Arbitration is per packet. Non-granted sources are only stalled, never dropped.
- Reset values: state IDLE, `last_grant`=NUM_SRC-1 (so source 0 wins first), `grant_id`=0, `busy`=0, `m00_axis_tvalid`=0, all `s_axis_tready`=0.
- `m00_axis_tdata`/`tkeep`/`tlast`/`tuser` are 0 whenever the state is not XFER.
- A `tvalid` drop from the granted source mid-packet keeps the grant. The arbiter waits.
- Reset asserted mid-packet: state returns to IDLE on the next edge. Downstream sees a truncated packet; this is acceptable, and the MAC relies on the link reset.

## Timing
- Arbitration latency: `tvalid` seen in IDLE at edge N gives a grant at edge N+1. The first beat is offered in cycle N+1.
- Exactly one idle bubble between consecutive packets: the tlast handshake cycle, then one IDLE cycle.
- Zero added latency per beat inside a packet, because the datapath is a combinational mux.
- Backpressure: `m00_axis_tready`=0 holds the granted source's `tready` low in the same cycle.
- Simultaneous requests are resolved purely by the round-robin pointer. A single requester wins immediately regardless of pointer position.

## Configuration
- `UDP_ARB_WATCHDOG_EN` defined:
  - A beat counter, cleared on grant, counts accepted XFER beats.
  - If the beat with count == MAX_BEATS-1 is accepted without source `tlast`, the arbiter drives `m00_axis_tlast`=1 and `m00_axis_tuser`=1 on that beat, then enters DRAIN.
  - In DRAIN, `s_axis_tready[grant_id]`=1 and `m00_axis_tvalid`=0. Source beats are discarded until a source `tlast` handshake, then the state goes to IDLE.
  - A source `tlast` exactly on beat MAX_BEATS is legal and passes unmodified.
- Macro undefined: no counter and no DRAIN state; `tuser` passes through unchanged.

## Structure
- Shared package `udp_stream_pkg` holds:
  - the state enum `arb_state_t` (IDLE, XFER, DRAIN);
  - the constants `UDP_AXIS_DATA_W`=64 and `UDP_AXIS_KEEP_W`=8.
- One sub-module: `rr_arbiter`, a combinational round-robin priority picker with inputs req[NUM_SRC] and pointer, and outputs a one-hot grant and an index.
- The FSM, beat counter and mux live in the top.

## Test plan
- Single source, 4-beat packet on source 2 with `m00_axis_tready`=1 → `grant_id`=2 one cycle after `tvalid`; 4 beats out identical to the input; `tlast` on beat 4; `busy` falls the cycle after.
- Sources 0 and 1 request together out of reset, 3-beat packets each → source 0's packet first, then one idle cycle, then source 1's; no interleaving.
- All 4 sources requesting continuously, 2-beat packets → grant sequence 0,1,2,3,0,1; each source gets exactly 2 packets in 8 grants.
- Backpressure: `m00_axis_tready` toggling 1,0,1,0 during a 6-beat packet → the source's `tready` mirrors it; beats are neither lost nor duplicated.
- Watchdog (MAX_BEATS=8, macro on), 12-beat packet on source 1 → 8 beats out, the 8th with `tlast`=1 and `tuser`=1; 4 beats absorbed with `m00_axis_tvalid`=0; next grant after that. With the macro off, all 12 beats pass through.
- Reset asserted after beat 2 of a 5-beat packet → the next cycle shows `m00_axis_tvalid`=0, all `s_axis_tready`=0, `busy`=0; after release, source 0 wins first.

Source files
------------

// File: rtl/udp_stream_pkg.sv
// Shared types and constants for the UDP stream egress path.
// Holds the arbiter state encoding and the 64-bit AXI4-Stream beat geometry.
package udp_stream_pkg;

    localparam int unsigned UDP_AXIS_DATA_W = 64;
    localparam int unsigned UDP_AXIS_KEEP_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr_i wins.
// Returns the winner both one-hot and as a binary index.
module rr_arbiter #(
    parameter int unsigned NumSrc = 4,
    parameter int unsigned IdxW   = $clog2(NumSrc)
) (
    input  logic [NumSrc-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumSrc-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NumSrc);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/udp_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream egress among NUM_SRC sources.
// Define UDP_ARB_WATCHDOG_EN to truncate packets longer than MAX_BEATS beats.
module udp_stream_arbiter
    import udp_stream_pkg::*;
#(
    parameter int unsigned NUM_SRC            = 4,
    parameter int unsigned C_AXIS_TDATA_WIDTH = UDP_AXIS_DATA_W,
    parameter int unsigned C_AXIS_TKEEP_WIDTH = UDP_AXIS_KEEP_W,
    parameter int unsigned MAX_BEATS          = 256
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                    s_axis_tlast,
    input  logic [NUM_SRC-1:0]                    s_axis_tuser,
    output logic [NUM_SRC-1:0]                    s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]         m00_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]         m00_axis_tkeep,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic                                  m00_axis_tuser,
    input  logic                                  m00_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]            grant_id,
    output logic                                  busy
);

    localparam int unsigned IdxW = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_BEATS < 1 ||
        C_AXIS_TKEEP_WIDTH * 8 != C_AXIS_TDATA_WIDTH) begin : g_bad_params
        $error("udp_stream_arbiter: unsupported parameter combination");
    end

    arb_state_t          state_q, state_d;
    logic [IdxW-1:0]     grant_id_q, grant_id_d;
    logic [IdxW-1:0]     last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0]  gnt_oh_q, gnt_oh_d;

    logic [NUM_SRC-1:0]  rr_gnt;
    logic [IdxW-1:0]     rr_idx;
    logic [IdxW-1:0]     rr_ptr;

    logic [C_AXIS_TDATA_WIDTH-1:0] sel_tdata;
    logic [C_AXIS_TKEEP_WIDTH-1:0] sel_tkeep;
    logic                          sel_tvalid;
    logic                          sel_tlast;
    logic                          sel_tuser;
    logic                          xfer_hs;

    assign rr_ptr = (last_grant_q == IdxW'(NUM_SRC - 1)) ? '0 : last_grant_q + IdxW'(1);

    rr_arbiter #(
        .NumSrc (NUM_SRC),
        .IdxW   (IdxW)
    ) u_rr_arbiter (
        .req_i (s_axis_tvalid),
        .ptr_i (rr_ptr),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    assign sel_tdata  = s_axis_tdata[int'(grant_id_q) * C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
    assign sel_tkeep  = s_axis_tkeep[int'(grant_id_q) * C_AXIS_TKEEP_WIDTH +: C_AXIS_TKEEP_WIDTH];
    assign sel_tvalid = s_axis_tvalid[grant_id_q];
    assign sel_tlast  = s_axis_tlast[grant_id_q];
    assign sel_tuser  = s_axis_tuser[grant_id_q];
    assign xfer_hs    = sel_tvalid && m00_axis_tready;

`ifdef UDP_ARB_WATCHDOG_EN
    localparam int unsigned CntW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic            wd_trip;

    // Forced tlast depends only on the count, never on downstream ready.
    assign wd_trip = (beat_cnt_q == CntW'(MAX_BEATS - 1)) && !sel_tlast;
`endif

    always_comb begin
        state_d         = state_q;
        grant_id_d      = grant_id_q;
        last_grant_d    = last_grant_q;
        gnt_oh_d        = gnt_oh_q;
`ifdef UDP_ARB_WATCHDOG_EN
        beat_cnt_d      = beat_cnt_q;
`endif
        s_axis_tready   = '0;
        m00_axis_tdata  = '0;
        m00_axis_tkeep  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tuser  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|s_axis_tvalid) begin
                    state_d      = StXfer;
                    grant_id_d   = rr_idx;
                    last_grant_d = rr_idx;
                    gnt_oh_d     = rr_gnt;
`ifdef UDP_ARB_WATCHDOG_EN
                    beat_cnt_d   = '0;
`endif
                end
            end

            StXfer: begin
                m00_axis_tdata  = sel_tdata;
                m00_axis_tkeep  = sel_tkeep;
                m00_axis_tvalid = sel_tvalid;
                m00_axis_tlast  = sel_tlast;
                m00_axis_tuser  = sel_tuser;
                s_axis_tready   = gnt_oh_q & {NUM_SRC{m00_axis_tready}};
`ifdef UDP_ARB_WATCHDOG_EN
                if (wd_trip) begin
                    m00_axis_tlast = 1'b1;
                    m00_axis_tuser = 1'b1;
                end
`endif
                if (xfer_hs) begin
                    if (sel_tlast) begin
                        state_d = StIdle;
`ifdef UDP_ARB_WATCHDOG_EN
                    end else if (wd_trip) begin
                        state_d = StDrain;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
`endif
                    end
                end
            end

`ifdef UDP_ARB_WATCHDOG_EN
            // Swallow the rest of the oversized packet so the source can move on.
            StDrain: begin
                s_axis_tready = gnt_oh_q;
                if (sel_tvalid && sel_tlast) begin
                    state_d = StIdle;
                end
            end
`endif

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_grant_q <= IdxW'(NUM_SRC - 1);
            gnt_oh_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            gnt_oh_q     <= gnt_oh_d;
        end
    end

`ifdef UDP_ARB_WATCHDOG_EN
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    assign grant_id = grant_id_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Randomized scoreboard bench for udp_stream_arbiter with a packet-level reference model.
// Also honours UDP_ARB_WATCHDOG_EN when the design is built with it.
module tb_udp_stream_arbiter;

    localparam int unsigned NSrc     = 4;
    localparam int unsigned W        = 64;
    localparam int unsigned K        = 8;
    localparam int unsigned MaxBeats = 8;
    localparam int unsigned MaxB     = 512;
    localparam int unsigned NPkt     = 8;
    localparam int          Budget   = 20000;
`ifdef UDP_ARB_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic [K-1:0] keep;
        logic         last;
        logic         user;
    } beat_t;

    typedef struct packed {
        beat_t      b;
        logic [1:0] src;
    } exp_t;

    logic                clk;
    logic                aresetn;
    logic [NSrc*W-1:0]   s_tdata;
    logic [NSrc*K-1:0]   s_tkeep;
    logic [NSrc-1:0]     s_tvalid;
    logic [NSrc-1:0]     s_tlast;
    logic [NSrc-1:0]     s_tuser;
    logic [NSrc-1:0]     s_tready;
    logic [W-1:0]        m_tdata;
    logic [K-1:0]        m_tkeep;
    logic                m_tvalid;
    logic                m_tlast;
    logic                m_tuser;
    logic                m_tready;
    logic [1:0]          grant_id;
    logic                busy;

    udp_stream_arbiter #(
        .NUM_SRC            (NSrc),
        .C_AXIS_TDATA_WIDTH (W),
        .C_AXIS_TKEEP_WIDTH (K),
        .MAX_BEATS          (MaxBeats)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (aresetn),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .s_axis_tready    (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tkeep   (m_tkeep),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tuser   (m_tuser),
        .m00_axis_tready  (m_tready),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t beats [NSrc][MaxB];
    int    n_beats [NSrc];
    int    rd [NSrc];   // driver position (advanced on observed handshakes)
    int    mrd [NSrc];  // model position (advanced on predicted handshakes)
    exp_t  exp_q [$];
    int    total;
    int    bad;
    bit    mon_en;

    // Model: 0 idle, 1 transferring, 2 draining.
    int         m_st;
    int         m_w;
    int         m_last;
    int         m_cnt;
    logic [1:0] m_gid;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic drive_random();
        beat_t b;
        for (int k = 0; k < NSrc; k++) begin
            if (rd[k] < n_beats[k]) begin
                b           = beats[k][rd[k]];
                s_tvalid[k] = ($urandom_range(0, 3) != 0);
            end else begin
                b           = '0;
                s_tvalid[k] = 1'b0;
            end
            s_tdata[k*W +: W] = b.data;
            s_tkeep[k*K +: K] = b.keep;
            s_tlast[k]        = b.last;
            s_tuser[k]        = b.user;
        end
        m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic model_step();
        logic [NSrc-1:0] exp_rdy;
        beat_t           b;
        exp_t            e;
        bit              found;
        bit              done;
        int              c;

        exp_rdy = '0;
        if (m_st == 1) exp_rdy[m_w] = m_tready;
        else if (m_st == 2) exp_rdy[m_w] = 1'b1;
        check("s_tready", 128'(s_tready), 128'(exp_rdy));
        check("busy", 128'(busy), 128'(m_st != 0));
        check("grant_id", 128'(grant_id), 128'(m_gid));
        if (m_st != 1) check("m_tvalid_quiet", 128'(m_tvalid), 128'(0));

        for (int k = 0; k < NSrc; k++) begin
            if (s_tvalid[k] && s_tready[k]) rd[k]++;
        end

        case (m_st)
            0: begin
                found = 1'b0;
                for (int i = 1; i <= NSrc; i++) begin
                    c = (m_last + i) % NSrc;
                    if (!found && s_tvalid[c]) begin
                        found = 1'b1;
                        m_w   = c;
                    end
                end
                if (found) begin
                    m_last = m_w;
                    m_gid  = 2'(m_w);
                    m_st   = 1;
                    m_cnt  = 0;
                    done   = 1'b0;
                    for (int i = 0; i < MaxB && !done; i++) begin
                        b = beats[m_w][mrd[m_w] + i];
                        if (WdEn && i == MaxBeats - 1 && !b.last) begin
                            b.last = 1'b1;
                            b.user = 1'b1;
                            done   = 1'b1;
                        end
                        e.b   = b;
                        e.src = 2'(m_w);
                        exp_q.push_back(e);
                        if (b.last) done = 1'b1;
                    end
                end
            end
            1: begin
                if (s_tvalid[m_w] && m_tready) begin
                    b = beats[m_w][mrd[m_w]];
                    mrd[m_w]++;
                    m_cnt++;
                    if (b.last) m_st = 0;
                    else if (WdEn && m_cnt == MaxBeats) m_st = 2;
                end
            end
            default: begin
                if (s_tvalid[m_w]) begin
                    b = beats[m_w][mrd[m_w]];
                    mrd[m_w]++;
                    if (b.last) m_st = 0;
                end
            end
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL egress_beat: got data %h, expected no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("egress_beat", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(e.b));
                    check("egress_src", 128'(grant_id), 128'(e.src));
                end
            end
        end
    end

    initial begin : stim
        int  cycles;
        int  len;
        bit  drained;

        total   = 0;
        bad     = 0;
        mon_en  = 1'b0;
        m_st    = 0;
        m_w     = 0;
        m_cnt   = 0;
        m_last  = NSrc - 1;
        m_gid   = '0;
        aresetn = 1'b0;
        m_tready = 1'b1;
        s_tdata  = '1;
        s_tkeep  = '1;
        s_tvalid = '1;
        s_tlast  = '0;
        s_tuser  = '1;

        for (int k = 0; k < NSrc; k++) begin
            n_beats[k] = 0;
            rd[k]      = 0;
            mrd[k]     = 0;
            for (int p = 0; p < NPkt; p++) begin
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) begin
                    beats[k][n_beats[k]] = '{data: {$urandom, $urandom},
                                             keep: (i == len - 1) ? 8'($urandom_range(1, 255))
                                                                  : 8'hFF,
                                             last: (i == len - 1),
                                             user: ($urandom_range(0, 7) == 0)};
                    n_beats[k]++;
                end
            end
        end

        // Requests and ready present during reset must not leak through.
        repeat (2) @(negedge clk);
        #4;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant_id", 128'(grant_id), 128'(0));
        check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_s_tready", 128'(s_tready), 128'(0));
        check("rst_m_tdata", 128'({m_tdata, m_tlast, m_tuser}), 128'(0));

        @(negedge clk);
        aresetn  = 1'b1;
        s_tvalid = '0;
        m_tready = 1'b0;
        mon_en   = 1'b1;

        cycles  = 0;
        drained = 1'b0;
        while (!drained && cycles < Budget) begin
            @(negedge clk);
            drive_random();
            #4;
            model_step();
            cycles++;
            drained = (m_st == 0);
            for (int k = 0; k < NSrc; k++) begin
                if (rd[k] != n_beats[k]) drained = 1'b0;
            end
        end
        if (!drained) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d cycles without completion, expected under %0d",
                     cycles, Budget);
        end

        @(negedge clk);
        s_tvalid = '0;
        #4;
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        mon_en = 1'b0;

        // Lone requester wins at once, then reset lands mid-packet.
        @(negedge clk);
        s_tdata[2*W +: W] = 64'hA5A5_0002_DEAD_BEEF;
        s_tkeep[2*K +: K] = 8'hFF;
        s_tvalid          = 4'b0100;
        s_tlast           = '0;
        s_tuser           = '0;
        m_tready          = 1'b1;
        @(negedge clk);
        #4;
        check("lone_grant_id", 128'(grant_id), 128'(2));
        check("lone_busy", 128'(busy), 128'(1));
        check("lone_s_tready", 128'(s_tready), 128'(4'b0100));
        check("lone_m_tdata", 128'(m_tdata), 128'(64'hA5A5_0002_DEAD_BEEF));
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        #4;
        check("midrst_m_tvalid", 128'(m_tvalid), 128'(0));
        check("midrst_s_tready", 128'(s_tready), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_grant_id", 128'(grant_id), 128'(0));

        @(negedge clk);
        aresetn           = 1'b1;
        s_tdata[0 +: W]   = 64'h0000_0000_1234_5678;
        s_tkeep[0 +: K]   = 8'hFF;
        s_tvalid          = 4'b0101;
        @(negedge clk);
        #4;
        check("postrst_grant_id", 128'(grant_id), 128'(0));
        check("postrst_busy", 128'(busy), 128'(1));
        check("postrst_s_tready", 128'(s_tready), 128'(4'b0001));
        check("postrst_m_tdata", 128'({m_tvalid, m_tdata}), 128'({1'b1, 64'h1234_5678}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
